// File: rtl/regfile_sequencer_if.sv
// Instruction handshake plus register-file / ALU strobe bundle between the
// sequencer (master) and the datapath/instruction source (slave).
interface regfile_sequencer_if;
    logic [9:0] INSTR;
    logic       INSTR_VALID;
    logic       INSTR_READY;
    logic       EXT_VALID;
    logic       ENW;
    logic [1:0] WRA;
    logic       ENR0;
    logic [1:0] RDA0;
    logic       ENR1;
    logic [1:0] RDA1;
    logic [1:0] BUS_SEL;
    logic       A_LD;
    logic       G_LD;
    logic [1:0] ALU_OP;
    logic       DONE;
    logic       ILLEGAL;

    modport master (
        input  INSTR, INSTR_VALID, EXT_VALID,
        output INSTR_READY, ENW, WRA, ENR0, RDA0, ENR1, RDA1,
               BUS_SEL, A_LD, G_LD, ALU_OP, DONE, ILLEGAL
    );

    modport slave (
        output INSTR, INSTR_VALID, EXT_VALID,
        input  INSTR_READY, ENW, WRA, ENR0, RDA0, ENR1, RDA1,
               BUS_SEL, A_LD, G_LD, ALU_OP, DONE, ILLEGAL
    );
endinterface

// File: rtl/regfile_sequencer.sv
// Multi-cycle sequencer for a 4 x 10-bit register file: decodes one instruction
// per handshake and drives write/read/bus/ALU strobes as Moore outputs.
module regfile_sequencer (
    input  logic                       CLKb,
    input  logic                       RST,
    regfile_sequencer_if.master        bus
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_WAIT = 3'd1,
        S_LD_WR   = 3'd2,
        S_MOV_WR  = 3'd3,
        S_ALU_RD  = 3'd4,
        S_ALU_EX  = 3'd5,
        S_ALU_WB  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [9:0] r_ir;
    logic [9:0] w_ir_nxt;
    logic [2:0] w_op_diff;

    logic       w_ready, w_enw, w_enr0, w_enr1, w_ald, w_gld, w_done, w_illegal;
    logic [1:0] w_wra, w_rda0, w_rda1, w_bus_sel, w_alu_op;
    logic       r_ready, r_enw, r_enr0, r_enr1, r_ald, r_gld, r_done, r_illegal;
    logic [1:0] r_wra, r_rda0, r_rda1, r_bus_sel, r_alu_op;

    // State and instruction register; the outputs are registered from the
    // decode of the next state so they line up with the state they belong to.
    always_ff @(posedge CLKb) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_ir      <= 10'd0;
            r_ready   <= 1'b1;
            r_enw     <= 1'b0;
            r_wra     <= 2'd0;
            r_enr0    <= 1'b0;
            r_rda0    <= 2'd0;
            r_enr1    <= 1'b0;
            r_rda1    <= 2'd0;
            r_bus_sel <= 2'd0;
            r_ald     <= 1'b0;
            r_gld     <= 1'b0;
            r_alu_op  <= 2'd0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ir      <= w_ir_nxt;
            r_ready   <= w_ready;
            r_enw     <= w_enw;
            r_wra     <= w_wra;
            r_enr0    <= w_enr0;
            r_rda0    <= w_rda0;
            r_enr1    <= w_enr1;
            r_rda1    <= w_rda1;
            r_bus_sel <= w_bus_sel;
            r_ald     <= w_ald;
            r_gld     <= w_gld;
            r_alu_op  <= w_alu_op;
            r_done    <= w_done;
            r_illegal <= w_illegal;
        end
    end

    // Next-state and instruction-latch logic.
    always_comb begin
        w_state_nxt = r_state;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_IDLE: begin
                if (bus.INSTR_VALID) begin
                    w_ir_nxt = bus.INSTR;
                    case (bus.INSTR[9:7])
                        3'b000:                         w_state_nxt = S_LD_WAIT;
                        3'b001:                         w_state_nxt = S_MOV_WR;
                        3'b010, 3'b011, 3'b100, 3'b101: w_state_nxt = S_ALU_RD;
                        default:                        w_state_nxt = S_DONE;
                    endcase
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LD_WAIT: begin
                if (bus.EXT_VALID) begin
                    w_state_nxt = S_LD_WR;
                end else begin
                    w_state_nxt = S_LD_WAIT;
                end
            end
            S_LD_WR:  w_state_nxt = S_DONE;
            S_MOV_WR: w_state_nxt = S_DONE;
            S_ALU_RD: w_state_nxt = S_ALU_EX;
            S_ALU_EX: w_state_nxt = S_ALU_WB;
            S_ALU_WB: w_state_nxt = S_DONE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode for the upcoming state; ALU op codes are opcode minus 2.
    always_comb begin
        w_op_diff = w_ir_nxt[9:7] - 3'd2;
        w_ready   = 1'b0;
        w_enw     = 1'b0;
        w_wra     = 2'd0;
        w_enr0    = 1'b0;
        w_rda0    = 2'd0;
        w_enr1    = 1'b0;
        w_rda1    = 2'd0;
        w_bus_sel = 2'd0;
        w_ald     = 1'b0;
        w_gld     = 1'b0;
        w_alu_op  = 2'd0;
        w_done    = 1'b0;
        w_illegal = 1'b0;
        case (w_state_nxt)
            S_IDLE:    w_ready = 1'b1;
            S_LD_WAIT: w_ready = 1'b0;
            S_LD_WR: begin
                w_enw     = 1'b1;
                w_wra     = w_ir_nxt[6:5];
                w_bus_sel = 2'b01;
            end
            S_MOV_WR: begin
                w_enr0    = 1'b1;
                w_rda0    = w_ir_nxt[4:3];
                w_enw     = 1'b1;
                w_wra     = w_ir_nxt[6:5];
                w_bus_sel = 2'b11;
            end
            S_ALU_RD: begin
                w_enr0   = 1'b1;
                w_rda0   = w_ir_nxt[6:5];
                w_enr1   = 1'b1;
                w_rda1   = w_ir_nxt[4:3];
                w_ald    = 1'b1;
                w_alu_op = w_op_diff[1:0];
            end
            S_ALU_EX: begin
                w_enr1   = 1'b1;
                w_rda1   = w_ir_nxt[4:3];
                w_gld    = 1'b1;
                w_alu_op = w_op_diff[1:0];
            end
            S_ALU_WB: begin
                w_enw     = 1'b1;
                w_wra     = w_ir_nxt[6:5];
                w_bus_sel = 2'b10;
            end
            S_DONE: begin
                w_done    = 1'b1;
                w_illegal = (w_ir_nxt[9:8] == 2'b11);
            end
            default: w_ready = 1'b0;
        endcase
    end

    assign bus.INSTR_READY = r_ready;
    assign bus.ENW         = r_enw;
    assign bus.WRA         = r_wra;
    assign bus.ENR0        = r_enr0;
    assign bus.RDA0        = r_rda0;
    assign bus.ENR1        = r_enr1;
    assign bus.RDA1        = r_rda1;
    assign bus.BUS_SEL     = r_bus_sel;
    assign bus.A_LD        = r_ald;
    assign bus.G_LD        = r_gld;
    assign bus.ALU_OP      = r_alu_op;
    assign bus.DONE        = r_done;
    assign bus.ILLEGAL     = r_illegal;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Randomized bench: per-cycle strobe schedule plus a small datapath whose
// register contents are compared with an instruction-level register model.
module tb_regfile_sequencer;
    typedef logic [17:0] ov_t;
    localparam ov_t IDLE_OV = 18'h20000;

    logic CLKb = 1'b0;
    logic RST  = 1'b1;
    regfile_sequencer_if sif ();

    regfile_sequencer dut (.CLKb(CLKb), .RST(RST), .bus(sif.master));

    always #5 CLKb = ~CLKb;

    int n_tests = 0;
    int n_fail  = 0;

    wire ov_t dut_ov = {sif.INSTR_READY, sif.ENW, sif.WRA, sif.ENR0, sif.RDA0,
                        sif.ENR1, sif.RDA1, sif.BUS_SEL, sif.A_LD, sif.G_LD,
                        sif.ALU_OP, sif.DONE, sif.ILLEGAL};

    // Datapath stand-in: register file, operand A and result G, falling-edge sampled.
    logic [9:0] dp_r [4];
    logic [9:0] dp_a = 10'd0;
    logic [9:0] dp_g = 10'd0;
    logic [9:0] ext_bus = 10'd0;
    logic       dp_clr = 1'b1;
    logic [9:0] bus_v, alu_v;
    wire  [9:0] p0 = sif.ENR0 ? dp_r[sif.RDA0] : 10'd0;
    wire  [9:0] p1 = sif.ENR1 ? dp_r[sif.RDA1] : 10'd0;

    always_comb begin
        case (sif.BUS_SEL)
            2'b01:   bus_v = ext_bus;
            2'b10:   bus_v = dp_g;
            2'b11:   bus_v = p0;
            default: bus_v = 10'd0;
        endcase
        case (sif.ALU_OP)
            2'b00:   alu_v = dp_a + p1;
            2'b01:   alu_v = dp_a - p1;
            2'b10:   alu_v = dp_a ^ p1;
            default: alu_v = ~p1;
        endcase
    end

    always @(negedge CLKb) begin
        if (dp_clr) begin
            for (int k = 0; k < 4; k++) dp_r[k] <= 10'd0;
        end else begin
            if (sif.A_LD) dp_a <= p0;
            if (sif.G_LD) dp_g <= alu_v;
            if (sif.ENW)  dp_r[sif.WRA] <= bus_v;
        end
    end

    logic mon_en = 1'b0;
    int   enw_seen = 0;
    int   done_seen = 0;
    always @(negedge CLKb) begin
        if (mon_en && sif.ENW)  enw_seen  <= enw_seen + 1;
        if (mon_en && sif.DONE) done_seen <= done_seen + 1;
    end

    logic [9:0] m_r [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ov_t ov(input logic rdy, input logic enw, input logic [1:0] wra,
                               input logic enr0, input logic [1:0] rda0,
                               input logic enr1, input logic [1:0] rda1,
                               input logic [1:0] bsel, input logic ald, input logic gld,
                               input logic [1:0] op, input logic done, input logic ill);
        return {rdy, enw, wra, enr0, rda0, enr1, rda1, bsel, ald, gld, op, done, ill};
    endfunction

    task automatic check_regs(input string tag);
        for (int k = 0; k < 4; k++) check_eq($sformatf("%s_R%0d", tag, k), dp_r[k], m_r[k]);
    endtask

    // Issue one instruction from IDLE and check every cycle until back in IDLE.
    task automatic run_instr(input logic [9:0] instr, input int nwait,
                             input logic [9:0] ext, input bit hold);
        ov_t        q[$];
        logic [2:0] opc = instr[9:7];
        logic [1:0] rx  = instr[6:5];
        logic [1:0] ry  = instr[4:3];
        logic [2:0] d   = opc - 3'd2;
        logic [1:0] op  = d[1:0];
        case (opc)
            3'd0: begin
                for (int i = 0; i < nwait; i++)
                    q.push_back(ov(0,0,2'd0,0,2'd0,0,2'd0,2'b00,0,0,2'd0,0,0));
                q.push_back(ov(0,1,rx,0,2'd0,0,2'd0,2'b01,0,0,2'd0,0,0));
            end
            3'd1: q.push_back(ov(0,1,rx,1,ry,0,2'd0,2'b11,0,0,2'd0,0,0));
            3'd2, 3'd3, 3'd4, 3'd5: begin
                q.push_back(ov(0,0,2'd0,1,rx,1,ry,2'b00,1,0,op,0,0));
                q.push_back(ov(0,0,2'd0,0,2'd0,1,ry,2'b00,0,1,op,0,0));
                q.push_back(ov(0,1,rx,0,2'd0,0,2'd0,2'b10,0,0,2'd0,0,0));
            end
            default: ;
        endcase
        q.push_back(ov(0,0,2'd0,0,2'd0,0,2'd0,2'b00,0,0,2'd0,1,(opc > 3'd5)));

        check_eq("ready_before", {31'd0, sif.INSTR_READY}, 32'd1);
        sif.INSTR       = instr;
        sif.INSTR_VALID = 1'b1;
        sif.EXT_VALID   = 1'($urandom);
        ext_bus         = ext;
        @(posedge CLKb);
        foreach (q[i]) begin
            #1;
            if (hold) sif.INSTR = 10'($urandom);
            else      sif.INSTR_VALID = 1'b0;
            if (opc == 3'd0 && i < nwait) sif.EXT_VALID = (i == nwait - 1);
            else                          sif.EXT_VALID = 1'($urandom);
            @(negedge CLKb);
            check_eq($sformatf("op%0d_cyc%0d", opc, i + 1), dut_ov, q[i]);
            @(posedge CLKb);
        end
        #1;
        sif.INSTR_VALID = 1'b0;
        sif.INSTR       = 10'd0;
        sif.EXT_VALID   = 1'b0;
        case (opc)
            3'd0: m_r[rx] = ext;
            3'd1: m_r[rx] = m_r[ry];
            3'd2: m_r[rx] = m_r[rx] + m_r[ry];
            3'd3: m_r[rx] = m_r[rx] - m_r[ry];
            3'd4: m_r[rx] = m_r[rx] ^ m_r[ry];
            3'd5: m_r[rx] = ~m_r[ry];
            default: ;
        endcase
        @(negedge CLKb);
        check_eq($sformatf("op%0d_idle", opc), dut_ov, IDLE_OV);
        check_regs($sformatf("op%0d", opc));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sif.INSTR       = 10'd0;
        sif.INSTR_VALID = 1'b0;
        sif.EXT_VALID   = 1'b0;
        for (int k = 0; k < 4; k++) m_r[k] = 10'd0;
        repeat (2) @(posedge CLKb);
        @(negedge CLKb);
        check_eq("reset_state", dut_ov, IDLE_OV);
        RST    = 1'b0;
        dp_clr = 1'b0;
        @(negedge CLKb);
        check_eq("idle_no_valid", dut_ov, IDLE_OV);

        // LD R2 after three low EXT_VALID cycles
        run_instr(10'b000_10_00_000, 4, 10'h155, 1'b0);
        // MOV R1 <- R3
        run_instr(10'b000_11_00_000, 1, 10'h0A5, 1'b0);
        run_instr(10'b001_01_11_000, 1, 10'h000, 1'b0);
        // ADD with 10-bit wrap, then SUB with borrow
        run_instr(10'b000_00_00_000, 2, 10'h3FF, 1'b0);
        run_instr(10'b000_01_00_000, 1, 10'h002, 1'b0);
        run_instr(10'b010_00_01_000, 1, 10'h000, 1'b0);
        check_eq("add_wrap", dp_r[0], 10'h001);
        run_instr(10'b000_00_00_000, 1, 10'h000, 1'b0);
        run_instr(10'b000_01_00_000, 1, 10'h001, 1'b0);
        run_instr(10'b011_00_01_000, 1, 10'h000, 1'b0);
        check_eq("sub_wrap", dp_r[0], 10'h3FF);
        // Illegal opcode
        run_instr(10'b111_00_00_000, 1, 10'h000, 1'b0);
        // INSTR_VALID held with changing INSTR during an ADD, then back-to-back
        run_instr(10'b010_10_11_000, 1, 10'h000, 1'b1);
        run_instr(10'b100_11_10_000, 1, 10'h000, 1'b1);

        // Reset during ALU_EX aborts without write or DONE
        sif.INSTR       = 10'b010_01_01_000;
        sif.INSTR_VALID = 1'b1;
        @(posedge CLKb);
        #1 sif.INSTR_VALID = 1'b0;
        @(posedge CLKb);
        #1;
        RST    = 1'b1;
        mon_en = 1'b1;
        @(posedge CLKb);
        @(negedge CLKb);
        check_eq("rst_abort_1", dut_ov, IDLE_OV);
        @(posedge CLKb);
        #1 RST = 1'b0;
        @(negedge CLKb);
        check_eq("rst_abort_2", dut_ov, IDLE_OV);
        repeat (2) @(negedge CLKb);
        mon_en = 1'b0;
        @(negedge CLKb);
        check_eq("rst_no_enw", enw_seen, 32'd0);
        check_eq("rst_no_done", done_seen, 32'd0);
        check_regs("rst");

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            run_instr(10'($urandom), $urandom_range(1, 4), 10'($urandom),
                      1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Control-side initiator for the 4 x 10-bit register file of the datapath.
- Accepts one 10-bit instruction per handshake, decodes it, and sequences the register-file strobes over a fixed multi-cycle schedule: write enable/address, two read enables/addresses, and data-bus source select.
- Also drives ALU operand/result latch strobes and ALU op code.
- Sits between the instruction source (switches/instruction register path) and the datapath.

Parameters:
- none (data width fixed at 10, register count fixed at 4)

Ports:
- CLKb  in  1  system clock; every sequencer flop updates on the rising edge. The register file samples on the falling edge, so strobes are stable mid-cycle.
- RST  in  1  reset, synchronous, active-high.
- INSTR  in  10  instruction word: [9:7] opcode, [6:5] Rx (dest/operand A), [4:3] Ry (source/operand B), [2:0] ignored.
- INSTR_VALID  in  1  INSTR is valid.
- INSTR_READY  out  1  sequencer can accept an instruction.
- EXT_VALID  in  1  external immediate data is present on the data bus (used by LD).
- ENW  out  1  register file write enable.
- WRA  out  2  register file write address.
- ENR0  out  1  read port 0 enable.
- RDA0  out  2  read port 0 address.
- ENR1  out  1  read port 1 enable.
- RDA1  out  2  read port 1 address.
- BUS_SEL  out  2  data bus source: 00 none, 01 external, 10 ALU result G, 11 register read port 0.
- A_LD  out  1  latch read port 0 into ALU operand A.
- G_LD  out  1  latch ALU result into G.
- ALU_OP  out  2  00 add, 01 sub, 10 xor, 11 invert B.
- DONE  out  1  one-cycle pulse when an instruction completes.
- ILLEGAL  out  1  one-cycle pulse, coincident with DONE, for an undefined opcode.

Behaviour:
- Clocking and reset:
  - Single clock CLKb; reset synchronous, active-high.
  - While RST is high at a rising edge: state goes to IDLE and IR clears to 0.
  - Reset values: INSTR_READY=1, all other outputs 0 (BUS_SEL=00, addresses 00).
  - RST mid-instruction aborts it on the next edge with no further ENW; DONE does not pulse.
- Outputs are Moore: decoded from state and the latched IR only. Any output not listed for a state is 0.
- Opcodes: 000 LD, 001 MOV, 010 ADD, 011 SUB, 100 XOR, 101 INV; 110/111 illegal.
- States and outputs:
  - IDLE: INSTR_READY=1. On INSTR_VALID&INSTR_READY, latch INSTR into IR and branch on opcode. Otherwise stay.
  - LD_WAIT: wait while EXT_VALID=0. EXT_VALID is sampled at each rising edge; when it is 1, go to LD_WR. Minimum 1 cycle, no upper bound.
  - LD_WR (1 cycle): ENW=1, WRA=Rx, BUS_SEL=01 -> DONE.
  - MOV_WR (1 cycle): ENR0=1, RDA0=Ry, ENW=1, WRA=Rx, BUS_SEL=11 -> DONE. Rx==Ry is legal and rewrites the same value.
  - ALU_RD (1 cycle): ENR0=1, RDA0=Rx, ENR1=1, RDA1=Ry, A_LD=1, ALU_OP=opcode-2 -> ALU_EX.
  - ALU_EX (1 cycle): ENR1=1, RDA1=Ry, G_LD=1, ALU_OP held -> ALU_WB.
  - ALU_WB (1 cycle): ENW=1, WRA=Rx, BUS_SEL=10 -> DONE.
  - DONE (1 cycle): DONE=1; ILLEGAL=1 if the opcode was illegal -> IDLE.
  - Illegal opcode: IDLE -> DONE directly; no ENW, ENR0 or ENR1 asserted.
- Latency (accept edge = cycle 0):
  - MOV: write in cycle 1, DONE in cycle 2.
  - ALU ops: write in cycle 3, DONE in cycle 4.
  - LD: write one cycle after EXT_VALID is sampled high.
  - INSTR_READY returns one cycle after DONE.
- Handshake:
  - INSTR_READY is high only in IDLE.
  - INSTR and INSTR_VALID are ignored in every other state; no queuing.
  - EXT_VALID is ignored outside LD_WAIT.
- Write safety:
  - ENW is never high for more than 1 consecutive cycle per instruction.
  - ENW is never high in IDLE, LD_WAIT, ALU_RD, ALU_EX or DONE.
  - BUS_SEL is non-zero only in write states.

Test Plan:
1. RST=1 for 2 cycles mid-ALU_EX -> next edge: IDLE, INSTR_READY=1, ENW=0, DONE never pulses, all addresses 00.
2. LD R2: INSTR=10'b000_10_00_000 with INSTR_VALID; EXT_VALID low 3 cycles then high with bus=10'h155 -> exactly one ENW cycle, WRA=10, BUS_SEL=01; R2 reads 10'h155; DONE one cycle later.
3. MOV R1<-R3 (R3=10'h0A5): INSTR=10'b001_01_11_000 -> cycle 1: ENR0=1, RDA0=11, ENW=1, WRA=01, BUS_SEL=11; cycle 2: DONE; R1=10'h0A5.
4. ADD R0<-R0+R1 with R0=10'h3FF, R1=10'h002 -> ALU_RD/EX/WB strobes in cycles 1-3 with ALU_OP=00; R0=10'h001 (10-bit wrap); DONE in cycle 4. Repeat with SUB: R0=10'h000, R1=10'h001 -> R0=10'h3FF.
5. INSTR=10'b111_00_00_000 -> DONE=1 and ILLEGAL=1 in cycle 1; no ENW/ENR0/ENR1 at any cycle; IDLE in cycle 2.
6. INSTR_VALID held high with changing INSTR during an ADD -> only the first word executes; the next word is accepted in the cycle after DONE.
